// File: rtl/fp_accum_seq.sv
// Sequencer that feeds a multi-cycle FP adder as {running_sum, next_operand}.
// It returns the final sum of a programmed-length operand vector.
module fp_accum_seq #(
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             add_start,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   input  logic [31:0]      add_sum,
   input  logic             add_done,
   output logic             out_valid,
   output logic [31:0]      out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             err_timeout
);

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT - 1);
   localparam logic [LEN_W-1:0] ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FIRST  = 3'd1;
   localparam logic [2:0] S_NEXT   = 3'd2;
   localparam logic [2:0] S_ISSUE  = 3'd3;
   localparam logic [2:0] S_GAP    = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;
   localparam logic [2:0] S_RESULT = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [31:0]      acc_q, acc_d;
   logic [LEN_W-1:0] rem_q, rem_d, rem_dec;
   logic [TW-1:0]    timer_q, timer_d;
   logic             in_ready_q, in_ready_d;
   logic             add_start_q, add_start_d;
   logic [31:0]      add_a_q, add_a_d;
   logic [31:0]      add_b_q, add_b_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_data_q, out_data_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   assign rem_dec = (rem_q != {LEN_W{1'b0}}) ? (rem_q - ONE) : {LEN_W{1'b0}};

   // Next-state logic; every output is derived from the next state so it can be registered.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      timer_d = timer_q;
      add_a_d = add_a_q;
      add_b_d = add_b_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               rem_d   = cfg_len;
               acc_d   = 32'h0000_0000;
               err_d   = 1'b0;
               state_d = (cfg_len == {LEN_W{1'b0}}) ? S_RESULT : S_FIRST;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FIRST: begin
            if (in_valid && in_ready_q) begin
               acc_d   = in_data;
               rem_d   = rem_dec;
               state_d = (rem_q == ONE) ? S_RESULT : S_NEXT;
            end else begin
               state_d = S_FIRST;
            end
         end
         S_NEXT: begin
            if (in_valid && in_ready_q) begin
               add_a_d = acc_q;
               add_b_d = in_data;
               state_d = S_ISSUE;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_ISSUE: begin
            timer_d = {TW{1'b0}};
            state_d = S_GAP;
         end
         // The adder's done from the previous add is still visible here, so it is not sampled.
         S_GAP: state_d = S_WAIT;
         S_WAIT: begin
            if (add_done) begin
               acc_d   = add_sum;
               rem_d   = rem_dec;
               state_d = (rem_q == ONE) ? S_RESULT : S_NEXT;
            end else if (timer_q == TMAX) begin
               err_d   = 1'b1;
               state_d = S_RESULT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_RESULT: begin
            if (out_ready && out_valid_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESULT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_FIRST) || (state_d == S_NEXT);
      add_start_d = (state_d == S_ISSUE);
      out_valid_d = (state_d == S_RESULT);
      busy_d      = (state_d != S_IDLE);
      if ((state_d == S_RESULT) && (state_q != S_RESULT)) begin
         out_data_d = acc_d;
      end else begin
         out_data_d = out_data_q;
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         acc_q       <= 32'h0000_0000;
         rem_q       <= {LEN_W{1'b0}};
         timer_q     <= {TW{1'b0}};
         in_ready_q  <= 1'b0;
         add_start_q <= 1'b0;
         add_a_q     <= 32'h0000_0000;
         add_b_q     <= 32'h0000_0000;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'h0000_0000;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         rem_q       <= rem_d;
         timer_q     <= timer_d;
         in_ready_q  <= in_ready_d;
         add_start_q <= add_start_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign add_start   = add_start_q;
   assign add_a       = add_a_q;
   assign add_b       = add_b_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a table-driven multi-cycle adder model.
module tb_fp_accum_seq;

   localparam int LEN_W   = 8;
   localparam int TIMEOUT = 64;
   localparam int L       = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             go = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             in_valid = 1'b0;
   logic [31:0]      in_data = 32'h0;
   logic             in_ready;
   logic             add_start;
   logic [31:0]      add_a, add_b;
   logic [31:0]      add_sum;
   logic             add_done;
   logic             out_valid;
   logic [31:0]      out_data;
   logic             out_ready = 1'b0;
   logic             busy;
   logic             err_timeout;

   int total = 0;
   int bad   = 0;
   int starts = 0;
   int ir_cnt = 0;
   int stab_err = 0;
   bit hang = 1'b0;
   logic [31:0] a_l, b_l;
   int cnt;

   fp_accum_seq #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .go(go), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .add_start(add_start), .add_a(add_a), .add_b(add_b),
      .add_sum(add_sum), .add_done(add_done),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Hand-computed single-precision sums for the operand pairs the tests use.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: fadd = 32'h40400000;
         {32'h40000000, 32'h3F800000}: fadd = 32'h40400000;
         {32'h40400000, 32'h40400000}: fadd = 32'h40C00000;
         {32'h3F800000, 32'h3F800000}: fadd = 32'h40000000;
         {32'h40400000, 32'h3F800000}: fadd = 32'h40800000;
         default:                      fadd = 32'hDEADBEEF;
      endcase
   endfunction

   // Adder model: done drops one edge after start is seen and rises L edges after start.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 0; add_done <= 1'b0; add_sum <= 32'h0; a_l <= 32'h0; b_l <= 32'h0;
      end else if (add_start) begin
         a_l <= add_a; b_l <= add_b; cnt <= L;
      end else if (cnt != 0) begin
         cnt <= cnt - 1;
         if (cnt == L) add_done <= 1'b0;
         if (cnt == 1 && !hang) begin
            add_done <= 1'b1;
            add_sum  <= fadd(a_l, b_l);
         end
      end
   end

   always @(posedge clk) begin
      if (add_start) starts <= starts + 1;
      if (in_ready) ir_cnt <= ir_cnt + 1;
      if (!reset && cnt != 0 && (add_a != a_l || add_b != b_l)) stab_err <= stab_err + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_go(input logic [LEN_W-1:0] len);
      @(negedge clk);
      go = 1'b1; cfg_len = len;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic push(input logic [31:0] d, input bit gap);
      int t = 0;
      if (gap) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1; in_data = d;
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_wait", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [31:0] exp, input int hold);
      int t = 0;
      while (!out_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_data"}, out_data, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_data"}, out_data, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      int s0, i0, st0;
      repeat (2) @(negedge clk);
      check("reset_outs", {in_ready, add_start, out_valid, busy, err_timeout, 27'b0}, 32'd0);
      check("reset_data", out_data | add_a | add_b, 32'd0);
      reset = 1'b0;

      // 1.0 + 2.0 + 3.0
      s0 = starts; st0 = stab_err;
      do_go(8'd3);
      push(32'h3F800000, 1'b0); push(32'h40000000, 1'b0); push(32'h40400000, 1'b0);
      wait_result("sum3", 32'h40C00000, 0);
      check("sum3_starts", starts - s0, 32'd2);
      check("sum3_err", {31'b0, err_timeout}, 32'd0);
      check("sum3_stable", stab_err - st0, 32'd0);

      // Zero-length vector
      s0 = starts; i0 = ir_cnt;
      do_go(8'd0);
      wait_result("len0", 32'h00000000, 0);
      check("len0_in_ready", ir_cnt - i0, 32'd0);
      check("len0_starts", starts - s0, 32'd0);

      // Single element passes through untouched
      s0 = starts;
      do_go(8'd1);
      push(32'h40490FDB, 1'b0);
      wait_result("len1", 32'h40490FDB, 0);
      check("len1_starts", starts - s0, 32'd0);

      // Four ones with input bubbles and an output stall
      s0 = starts; st0 = stab_err;
      do_go(8'd4);
      for (int k = 0; k < 4; k++) push(32'h3F800000, 1'b1);
      wait_result("len4", 32'h40800000, 5);
      check("len4_starts", starts - s0, 32'd3);
      check("len4_stable", stab_err - st0, 32'd0);

      // Adder never completes: stale done must be ignored and the timeout must fire
      hang = 1'b1;
      do_go(8'd2);
      push(32'h3F800000, 1'b0); push(32'h40000000, 1'b0);
      wait_result("tmo", 32'h3F800000, 0);
      check("tmo_err", {31'b0, err_timeout}, 32'd1);
      hang = 1'b0;
      do_go(8'd0);
      check("tmo_err_clear", {31'b0, err_timeout}, 32'd0);
      wait_result("tmo_next", 32'h00000000, 0);

      // Asynchronous reset while waiting on the adder
      do_go(8'd2);
      push(32'h3F800000, 1'b0); push(32'h3F800000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_busy", {31'b0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_outs", {in_ready, add_start, out_valid, busy, err_timeout, 27'b0}, 32'd0);
      check("async_reset_data", out_data | add_a | add_b, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      do_go(8'd2);
      push(32'h3F800000, 1'b0); push(32'h3F800000, 1'b0);
      wait_result("post_reset", 32'h40000000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
